// File: rtl/cntr_pwm_gen_pkg.sv
// Shared constants for the PWM generator that follows the free-running cntr block.
// Also used by the testbench so both agree on widths and the saturation value.
package cntr_pwm_gen_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned PCNT_W = 16;
  localparam logic [PCNT_W-1:0] PCNT_SAT = '1;

endpackage

// File: rtl/cntr_pwm_gen_if.sv
// Duty-write handshake between a controller and cntr_pwm_gen.
// The master drives duty_in/duty_wr; the PWM block reports duty_busy while a write is pending.
interface cntr_pwm_gen_if
  import cntr_pwm_gen_pkg::*;
#(
  parameter int unsigned N = N_DEF
);

  logic [N:0] duty_in;
  logic       duty_wr;
  logic       duty_busy;

  modport master (output duty_in, output duty_wr, input duty_busy);
  modport slave  (input duty_in, input duty_wr, output duty_busy);

endinterface

// File: rtl/cntr_pwm_gen_wrap_det.sv
// Wrap detector for the incoming counter value: any decrease of cntr_in
// relative to the previous cycle is a wrap. Also registers the period tick.
module cntr_wrap_det
  import cntr_pwm_gen_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] cntr_in,
  output logic         wrap,
  output logic         period_tick
);

  logic [N-1:0] prev_cnt;

  // Previous counter value starts at 0, so cntr_in = 0 right after reset is not a wrap.
  assign wrap = (cntr_in < prev_cnt);

  // Track the last counter value and delay the wrap into a one-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt    <= '0;
      period_tick <= 1'b0;
    end else begin
      prev_cnt    <= cntr_in;
      period_tick <= wrap;
    end
  end

endmodule

// File: rtl/cntr_pwm_gen.sv
// PWM generator driven by an external N-bit up-counter. Duty writes are
// shadow-buffered and applied only at a counter wrap, so no runt pulses occur.
// Optional: define PWM_PERIOD_CNT_EN to add a saturating 16-bit wrap counter
// on port period_cnt.
module cntr_pwm_gen
  import cntr_pwm_gen_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        cntr_in,
  cntr_pwm_gen_if.slave       duty,
  output logic                pwm_out,
  output logic                period_tick
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [PCNT_W-1:0]   period_cnt
`endif
);

  localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};

  logic       wrap;
  logic [N:0] duty_active;
  logic [N:0] duty_pending;
  logic       pending_valid;
  logic [N:0] duty_clamped;
  logic [N:0] duty_eff;

  cntr_wrap_det #(.N(N)) u_wrap_det (
    .clk         (clk),
    .reset       (reset),
    .cntr_in     (cntr_in),
    .wrap        (wrap),
    .period_tick (period_tick)
  );

  // Clamp requested duty to a full period and pick the duty in force this cycle.
  always_comb begin
    duty_clamped = (duty.duty_in > DUTY_MAX) ? DUTY_MAX : duty.duty_in;
    duty_eff     = (wrap && pending_valid) ? duty_pending : duty_active;
  end

  assign duty.duty_busy = pending_valid;

  // Shadow register: apply the previously pending duty at a wrap; a write in
  // the same cycle becomes the new pending value and keeps pending_valid set.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_active   <= '0;
      duty_pending  <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (wrap && pending_valid) begin
        duty_active <= duty_pending;
      end
      if (duty.duty_wr) begin
        duty_pending  <= duty_clamped;
        pending_valid <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Registered comparator: output high while the counter is below the duty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= ({1'b0, cntr_in} < duty_eff);
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  // Count wraps since reset, holding at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (wrap && (period_cnt != PCNT_SAT)) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end
`else
  // Period counter not built.
`endif

endmodule

// File: tb/tb_cntr_pwm_gen.sv
// Self-checking bench for cntr_pwm_gen (N = 8). The bench plays the role of the
// upstream counter and checks every cycle against a rule-level model, plus a
// per-period high-time count against the duty that governed that period.
`timescale 1ns/1ps
module tb_cntr_pwm_gen;
  import cntr_pwm_gen_pkg::*;

  localparam int PER = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cntr_in = '0;
  logic       pwm_out;
  logic       period_tick;
`ifdef PWM_PERIOD_CNT_EN
  logic [PCNT_W-1:0] period_cnt;
`endif

  cntr_pwm_gen_if #(.N(8)) dif ();

  cntr_pwm_gen #(.N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cntr_in     (cntr_in),
    .duty        (dif),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
`ifdef PWM_PERIOD_CNT_EN
    ,
    .period_cnt  (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (spec-level rules, plain integers)
  int m_prev = 0;
  int m_active = 0;
  int m_pending = 0;
  bit m_pvalid = 0;
  int m_pcnt = 0;

  // Bench-side counter and period window bookkeeping
  int cur = 0;
  int win_n = -1000000;
  int win_hi = 0;
  int win_duty = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int exp_pwm, input int exp_tick);
    check("pwm_out", {31'd0, pwm_out}, exp_pwm);
    check("period_tick", {31'd0, period_tick}, exp_tick);
    check("duty_busy", {31'd0, dif.duty_busy}, {31'd0, m_pvalid});
`ifdef PWM_PERIOD_CNT_EN
    check("period_cnt", {16'd0, period_cnt}, m_pcnt);
`endif
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    cntr_in = '0;
    dif.duty_wr = 1'b0;
    dif.duty_in = '0;
    m_prev = 0; m_active = 0; m_pending = 0; m_pvalid = 0; m_pcnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      check_all(0, 0);
    end
    reset = 1'b0;
    cur = 0;
    win_n = -1000000;
  endtask

  // Present counter value c for one clock, optionally with a duty write.
  task automatic tick_at(input int c, input bit wr, input int din);
    bit wrap;
    int eff, exp_pwm, exp_tick;
    if (c != cur) win_n = -1000000;
    cntr_in = 8'(c);
    dif.duty_wr = wr;
    dif.duty_in = 9'(din);
    wrap = (c < m_prev);
    eff = (wrap && m_pvalid) ? m_pending : m_active;
    exp_pwm = (c < eff) ? 1 : 0;
    exp_tick = wrap ? 1 : 0;
    if (wrap && m_pvalid) begin
      m_active = m_pending;
      m_pvalid = 0;
    end
    if (wr) begin
      m_pending = (din > PER) ? PER : din;
      m_pvalid = 1;
    end
    if (wrap && m_pcnt < 65535) m_pcnt++;
    m_prev = c;
    @(posedge clk); #1;
    dif.duty_wr = 1'b0;
    check_all(exp_pwm, exp_tick);
    if (c == 0) begin
      if (win_n == PER) check("period_high", win_hi, win_duty);
      win_n = 0;
      win_hi = 0;
      win_duty = eff;
    end
    win_n++;
    win_hi += int'(pwm_out);
    cur = (c + 1) % PER;
  endtask

  task automatic tick(input bit wr, input int din);
    tick_at(cur, wr, din);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 0);
  endtask

  task automatic run_to(input int c);
    int guard = 0;
    while (cur != c && guard < 2 * PER) begin
      tick(1'b0, 0);
      guard++;
    end
  endtask

  initial begin
    dif.duty_wr = 1'b0;
    dif.duty_in = '0;

    // Reset held 50 ns with counter at 0; no tick right after release
    do_reset(5);
    tick(1'b0, 0);
    check("no_tick_after_reset", {31'd0, period_tick}, 0);

    // Mid-period write of 64: busy until the wrap, then 64 high clocks
    run_to(100);
    tick(1'b1, 64);
    check("busy_after_wr", {31'd0, dif.duty_busy}, 1);
    run_to(0);
    run(2 * PER);

    // Boundary duties: 0, full period, and clamped over-range value
    tick(1'b1, 0);   run_to(0); run(PER + 3);
    tick(1'b1, 256); run_to(0); run(PER + 3);
    tick(1'b1, 300); run_to(0); run(PER + 3);
    tick(1'b1, 1);   run_to(0); run(PER + 3);

    // Two writes in one period: only the last one is applied
    run_to(30);  tick(1'b1, 10);
    run_to(150); tick(1'b1, 200);
    run_to(0);   run(PER + 3);

    // Write landing in the exact wrap cycle while 50 is pending
    run_to(120); tick(1'b1, 50);
    run_to(255); tick(1'b0, 0);
    tick_at(0, 1'b1, 77);
    check("busy_across_wrap", {31'd0, dif.duty_busy}, 1);
    run(2 * PER + 3);

    // Three full periods from reset, then a mid-period reset
    do_reset(5);
    tick(1'b1, 128);
    run(3 * PER - 1);
    tick(1'b0, 0);
`ifdef PWM_PERIOD_CNT_EN
    check("period_cnt_3", {16'd0, period_cnt}, 3);
`endif
    run_to(90);
    do_reset(1);
    check("pwm_after_mid_reset", {31'd0, pwm_out}, 0);

    // Randomized duty writes on a steadily counting input
    for (int i = 0; i < 6 * PER; i++) begin
      if ($urandom_range(0, 39) == 0) tick(1'b1, int'($urandom_range(0, 300)));
      else tick(1'b0, 0);
    end

    // Randomized counter jumps (any decrease counts as a wrap)
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0)
        tick_at(int'($urandom_range(0, PER - 1)), $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 300)));
      else
        tick($urandom_range(0, 49) == 0, int'($urandom_range(0, 300)));
    end
    run_to(0);
    run(PER + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
